// File: rtl/damage_pkg.sv
// Shared definitions for the damage resolver: colour codes, FSM states and
// the small colour-rule helpers used when a bullet overlaps the player.
package damage_pkg;

    typedef enum logic [2:0] {
        WHITE  = 3'd0,
        GREEN  = 3'd1,
        BLUE   = 3'd2,
        ORANGE = 3'd3
    } colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // White always hurts, blue hurts a moving player, orange a standing one.
    function automatic logic deals_damage(input logic [2:0] color, input logic moving);
        deals_damage = 1'b0;
        case (color)
            WHITE:   deals_damage = 1'b1;
            BLUE:    deals_damage = moving;
            ORANGE:  deals_damage = ~moving;
            default: deals_damage = 1'b0;
        endcase
    endfunction

    // Only green bullets heal; codes 4-7 are inert.
    function automatic logic gives_heal(input logic [2:0] color);
        gives_heal = (color == GREEN);
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Running total that adds a fixed step when enabled and sticks at all-ones
// instead of wrapping. A clear zeroes it for the start of a new pass.
module sat_accumulator #(
    parameter int DMG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [DMG_W-1:0] addend,
    output logic [DMG_W-1:0] total
);

    logic [DMG_W:0] sum;

    // One extra bit catches the carry that signals saturation.
    always_comb begin
        sum = {1'b0, total} + {1'b0, addend};
    end

    // Reset beats clear, clear beats accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            total <= '0;
        end else if (clear) begin
            total <= '0;
        end else if (en) begin
            total <= sum[DMG_W] ? '1 : sum[DMG_W-1:0];
        end
    end

endmodule

// File: rtl/damage_resolver.sv
// Walks every bullet slot once per start pulse, one slot per clock, and
// accumulates the damage and healing the player takes from overlapping
// live bullets. Totals become final with a one-cycle isComplete pulse.
module damage_resolver
    import damage_pkg::*;
#(
    parameter int N_BULLETS    = 8,
    parameter int DMG_W        = 8,
    parameter int ATTACK_POWER = 10,
    parameter int HEAL_POWER   = 5,
    localparam int IDX_W       = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isCollide,
    input  logic             isRender,
    input  logic             isMove,
    input  logic [2:0]       color,
    output logic [IDX_W-1:0] index,
    output logic [DMG_W-1:0] damage,
    output logic [DMG_W-1:0] healAmt,
    output logic             busy,
    output logic             isComplete
);

    localparam longint MAX_TOTAL = (longint'(1) << DMG_W) - 1;

    // Steps larger than the total width are clamped so one hit saturates.
    localparam logic [DMG_W-1:0] ATTACK_ADD =
        (longint'(ATTACK_POWER) > MAX_TOTAL) ? DMG_W'(MAX_TOTAL) : DMG_W'(ATTACK_POWER);
    localparam logic [DMG_W-1:0] HEAL_ADD =
        (longint'(HEAL_POWER) > MAX_TOTAL) ? DMG_W'(MAX_TOTAL) : DMG_W'(HEAL_POWER);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BULLETS - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] index_next;
    logic             complete_next;
    logic             hit;
    logic             dmg_en;
    logic             heal_en;

    // State, slot pointer and completion pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            isComplete <= 1'b0;
        end else begin
            state      <= state_next;
            index      <= index_next;
            isComplete <= complete_next;
        end
    end

    // Next state, pointer advance and hit qualification; start overrides all.
    always_comb begin
        state_next    = state;
        index_next    = index;
        complete_next = 1'b0;
        dmg_en        = 1'b0;
        heal_en       = 1'b0;
        hit           = isCollide & isRender;
        if (start) begin
            state_next = SCAN;
            index_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SCAN: begin
                    dmg_en  = hit & deals_damage(color, isMove);
                    heal_en = hit & gives_heal(color);
                    if (index == LAST_IDX) begin
                        state_next = DONE;
                        index_next = '0;
                    end else begin
                        index_next = index + IDX_W'(1);
                    end
                end
                DONE: begin
                    complete_next = 1'b1;
                    state_next    = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Busy reflects only the scanning state.
    always_comb begin
        busy = (state == SCAN);
    end

    sat_accumulator #(.DMG_W(DMG_W)) u_damage_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .en     (dmg_en),
        .addend (ATTACK_ADD),
        .total  (damage)
    );

    sat_accumulator #(.DMG_W(DMG_W)) u_heal_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .en     (heal_en),
        .addend (HEAL_ADD),
        .total  (healAmt)
    );

endmodule

// File: tb/tb_damage_resolver.sv
// Self-checking bench: a default-width resolver and a 5-bit one share the
// same stimulus; expected totals come from summing the colour rules per slot.
module tb_damage_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       isCollide;
    logic       isRender;
    logic       isMove;
    logic [2:0] color;

    logic [2:0] indexA;
    logic [7:0] damageA;
    logic [7:0] healA;
    logic       busyA;
    logic       doneA;

    logic [2:0] indexS;
    logic [4:0] damageS;
    logic [4:0] healS;
    logic       busyS;
    logic       doneS;

    int nChecks;
    int nFails;

    bit         slotCollide [8];
    bit         slotRender  [8];
    logic [2:0] slotColor   [8];
    bit         slotMove    [8];

    damage_resolver dutA (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .isCollide  (isCollide),
        .isRender   (isRender),
        .isMove     (isMove),
        .color      (color),
        .index      (indexA),
        .damage     (damageA),
        .healAmt    (healA),
        .busy       (busyA),
        .isComplete (doneA)
    );

    damage_resolver #(.DMG_W(5)) dutS (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .isCollide  (isCollide),
        .isRender   (isRender),
        .isMove     (isMove),
        .color      (color),
        .index      (indexS),
        .damage     (damageS),
        .healAmt    (healS),
        .busy       (busyS),
        .isComplete (doneS)
    );

    always #5 clk = ~clk;

    // Damage from the first 'upto' slots, capped at the total's maximum.
    function automatic int expDamage(input int upto, input int maxv);
        int sum = 0;
        for (int i = 0; i < upto; i++) begin
            if (slotCollide[i] && slotRender[i]) begin
                if (slotColor[i] == 3'd0) sum += 10;
                if (slotColor[i] == 3'd2 && slotMove[i]) sum += 10;
                if (slotColor[i] == 3'd3 && !slotMove[i]) sum += 10;
            end
        end
        return (sum > maxv) ? maxv : sum;
    endfunction

    function automatic int expHeal(input int upto, input int maxv);
        int sum = 0;
        for (int i = 0; i < upto; i++) begin
            if (slotCollide[i] && slotRender[i] && slotColor[i] == 3'd1) sum += 5;
        end
        return (sum > maxv) ? maxv : sum;
    endfunction

    task automatic checkValue(input string tag, input int obs, input int exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int expIdx, input bit expBusy,
                               input bit expDone, input int upto);
        if (expIdx >= 0) begin
            checkValue({tag, " indexA"}, int'(indexA), expIdx);
            checkValue({tag, " indexS"}, int'(indexS), expIdx);
        end
        checkValue({tag, " busyA"}, int'(busyA), int'(expBusy));
        checkValue({tag, " busyS"}, int'(busyS), int'(expBusy));
        checkValue({tag, " doneA"}, int'(doneA), int'(expDone));
        checkValue({tag, " doneS"}, int'(doneS), int'(expDone));
        checkValue({tag, " damageA"}, int'(damageA), expDamage(upto, 255));
        checkValue({tag, " healA"}, int'(healA), expHeal(upto, 255));
        checkValue({tag, " damageS"}, int'(damageS), expDamage(upto, 31));
        checkValue({tag, " healS"}, int'(healS), expHeal(upto, 31));
    endtask

    task automatic applyStimulus(input int k);
        isCollide = slotCollide[k];
        isRender  = slotRender[k];
        color     = slotColor[k];
        isMove    = slotMove[k];
    endtask

    task automatic applyIdle();
        isCollide = 1'($urandom_range(0, 1));
        isRender  = 1'($urandom_range(0, 1));
        color     = 3'($urandom_range(0, 7));
        isMove    = 1'($urandom_range(0, 1));
    endtask

    task automatic clearSlots();
        for (int i = 0; i < 8; i++) begin
            slotCollide[i] = 1'b0;
            slotRender[i]  = 1'b1;
            slotColor[i]   = 3'd0;
            slotMove[i]    = 1'b0;
        end
    endtask

    // Called at a falling edge; start is seen on the following rising edge.
    task automatic issueStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic scanSlots(input string tag);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(k);
            checkOutput($sformatf("%s slot%0d", tag, k), k, 1'b1, 1'b0, k);
            @(negedge clk);
        end
        applyIdle();
        checkOutput({tag, " done-state"}, -1, 1'b0, 1'b0, 8);
    endtask

    task automatic finishPass(input string tag);
        @(negedge clk);
        checkOutput({tag, " complete"}, -1, 1'b0, 1'b1, 8);
        @(negedge clk);
        checkOutput({tag, " after"}, -1, 1'b0, 1'b0, 8);
    endtask

    task automatic runPass(input string tag);
        issueStart();
        scanSlots(tag);
        finishPass(tag);
    endtask

    task automatic holdIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyIdle();
            @(negedge clk);
            checkOutput($sformatf("%s hold%0d", tag, i), -1, 1'b0, 1'b0, 8);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        clearSlots();
        applyStimulus(0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset", 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("reset idle", 0, 1'b0, 1'b0, 0);

        $display("[TB] single white hit at slot 3");
        clearSlots();
        slotCollide[3] = 1'b1;
        runPass("white3");
        checkValue("white3 const damage", int'(damageA), 10);
        checkValue("white3 const heal", int'(healA), 0);
        holdIdle("white3", 3);

        $display("[TB] blue/orange with player standing and moving");
        clearSlots();
        slotCollide[1] = 1'b1; slotColor[1] = 3'd2;
        slotCollide[2] = 1'b1; slotColor[2] = 3'd2;
        slotCollide[5] = 1'b1; slotColor[5] = 3'd3;
        runPass("still");
        checkValue("still const damage", int'(damageA), 10);
        for (int i = 0; i < 8; i++) slotMove[i] = 1'b1;
        runPass("moving");
        checkValue("moving const damage", int'(damageA), 20);

        $display("[TB] green everywhere, rendered and not");
        clearSlots();
        for (int i = 0; i < 8; i++) begin
            slotCollide[i] = 1'b1;
            slotColor[i]   = 3'd1;
        end
        runPass("green");
        checkValue("green const heal", int'(healA), 40);
        checkValue("green const damage", int'(damageA), 0);
        for (int i = 0; i < 8; i++) slotRender[i] = 1'b0;
        runPass("green-hidden");
        checkValue("green-hidden const heal", int'(healA), 0);

        $display("[TB] white everywhere saturates the narrow totals");
        clearSlots();
        for (int i = 0; i < 8; i++) slotCollide[i] = 1'b1;
        runPass("white-all");
        checkValue("white-all const damageA", int'(damageA), 80);
        checkValue("white-all const damageS", int'(damageS), 31);

        $display("[TB] reset mid-scan then restart");
        issueStart();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k);
            checkOutput($sformatf("abort slot%0d", k), k, 1'b1, 1'b0, k);
            @(negedge clk);
        end
        applyStimulus(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort reset", 0, 1'b0, 1'b0, 0);
        runPass("restart");

        $display("[TB] start coinciding with the completion cycle");
        clearSlots();
        slotCollide[0] = 1'b1; slotColor[0] = 3'd1;
        slotCollide[7] = 1'b1;
        issueStart();
        scanSlots("first");
        issueStart();
        scanSlots("second");
        finishPass("second");

        $display("[TB] random passes");
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) begin
                slotCollide[i] = 1'($urandom_range(0, 1));
                slotRender[i]  = 1'($urandom_range(0, 1));
                slotColor[i]   = 3'($urandom_range(0, 7));
                slotMove[i]    = 1'($urandom_range(0, 1));
            end
            runPass($sformatf("rand%0d", r));
            holdIdle($sformatf("rand%0d", r), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
